// File: rtl/inv_stim_check.sv
// Square-wave stimulus driver and latency-matched response checker for a
// single inverter cell; counts samples where resp fails to be ~drv.
module inv_stim_check #(
  parameter int HALF_PERIOD = 8,
  parameter int NTOGGLES    = 16,
  parameter int LAT         = 2,
  parameter int ERRW        = 8
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            start,
  input  logic            resp,
  output logic            drv,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt,
  output logic            mismatch,
  output logic [1:0]      dbg_state
);

  localparam int HCW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam int TCW = (NTOGGLES > 2) ? $clog2(NTOGGLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [HCW-1:0]  hc_q;
  logic [TCW-1:0]  tc_q;
  logic [2:0]      dc_q;
  logic            drv_q;
  logic            busy_q;
  logic            done_q;
  logic            mismatch_q;
  logic [ERRW-1:0] err_cnt_q;
  logic [LAT-1:0]  dpipe_q;
  logic [LAT-1:0]  vpipe_q;

  logic            mismatch_d;
  logic [ERRW-1:0] err_cnt_d;

  // A healthy inverter returns the opposite of the delayed stimulus, so equality is an error.
  always_comb begin
    mismatch_d = vpipe_q[LAT-1] && (resp == dpipe_q[LAT-1]);
    err_cnt_d  = err_cnt_q;
    if (mismatch_d && (err_cnt_q != {ERRW{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hc_q       <= '0;
      tc_q       <= '0;
      dc_q       <= '0;
      drv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
      dpipe_q    <= '0;
      vpipe_q    <= '0;
    end else begin
      dpipe_q[0] <= drv_q;
      vpipe_q[0] <= (state_q == S_RUN);
      for (int i = 1; i < LAT; i++) begin
        dpipe_q[i] <= dpipe_q[i-1];
        vpipe_q[i] <= vpipe_q[i-1];
      end
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            hc_q       <= '0;
            tc_q       <= '0;
            dc_q       <= '0;
            drv_q      <= 1'b0;
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            dpipe_q    <= '0;
            vpipe_q    <= '0;
          end
        end
        S_RUN: begin
          if (hc_q == HCW'(HALF_PERIOD - 1)) begin
            hc_q  <= '0;
            drv_q <= ~drv_q;
            tc_q  <= tc_q + TCW'(1);
            if (tc_q == TCW'(NTOGGLES - 1)) begin
              state_q <= S_DRAIN;
              dc_q    <= '0;
            end
          end else begin
            hc_q <= hc_q + HCW'(1);
          end
        end
        S_DRAIN: begin
          // Wait out the response latency so the final stimulus level is still checked.
          if (dc_q == 3'(LAT - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dc_q <= dc_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign drv       = drv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_cnt_q == '0);
  assign err_cnt   = err_cnt_q;
  assign mismatch  = mismatch_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inv_stim_check.sv
// Directed bench for inv_stim_check: behavioural inverter/buffer/stuck models
// with a 2-cycle delay drive resp; timing is counted in edges after the start edge.
module tb_inv_stim_check;

  localparam int T_DONE = 16 * 8 + 2;  // 130 edges after the start edge

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       resp;
  logic       drv, busy, done, pass, mismatch;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;

  logic       start4 = 1'b0;
  logic       resp4;
  logic       drv4, busy4, done4, pass4, mismatch4;
  logic [3:0] err_cnt4;
  logic [1:0] dbg_state4;

  // mode: 0 ideal inverter, 1 buffer, 2 stuck at 0; glitch flips resp for one cycle
  int   mode   = 0;
  logic glitch = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0, b1 = 1'b0, b2 = 1'b0;

  always @(posedge clk1) begin
    d1 <= drv;
    d2 <= d1;
    b1 <= drv4;
    b2 <= b1;
  end

  assign resp  = ((mode == 0) ? ~d2 : (mode == 1) ? d2 : 1'b0) ^ glitch;
  assign resp4 = b2;

  inv_stim_check dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .resp(resp),
    .drv(drv), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .mismatch(mismatch), .dbg_state(dbg_state)
  );

  inv_stim_check #(.ERRW(4)) dut4 (
    .clk1(clk1), .rst_n(rst_n), .start(start4), .resp(resp4),
    .drv(drv4), .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err_cnt4), .mismatch(mismatch4), .dbg_state(dbg_state4)
  );

  int errors = 0;
  int checks = 0;

  task automatic launch();
    @(negedge clk1);
    start = 1'b1;
    @(posedge clk1);
    #1;
    start = 1'b0;
  endtask

  // Samples #1 after each edge n = 1.. following the start edge until done is seen.
  task automatic watch(input int pulse_at, input int corrupt_edge,
                       output int n_done, output int n_mis,
                       output int first_mis, output int last_mis);
    n_done = -1; n_mis = 0; first_mis = -1; last_mis = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk1);
      #1;
      start  = (n == pulse_at - 1);
      glitch = (n == corrupt_edge - 1);
      if (mismatch) begin
        n_mis++;
        if (first_mis < 0) first_mis = n;
        last_mis = n;
      end
      if (done) begin
        n_done = n;
        break;
      end
    end
    start  = 1'b0;
    glitch = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    checks++; if (drv !== 1'b0)      begin errors++; $display("FAIL reset_drv: got %b expected 0", drv); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0)     begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (err_cnt !== 8'd0)  begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b expected 0", mismatch); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic test_ideal();
    int nd, nm, fm, lm;
    mode = 0;
    launch();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ideal_busy_after_start: got %b expected 1", busy); end
    checks++; if (drv !== 1'b0)  begin errors++; $display("FAIL ideal_drv_first: got %b expected 0", drv); end
    watch(0, 0, nd, nm, fm, lm);
    checks++; if (nd != T_DONE)     begin errors++; $display("FAIL ideal_done_edge: got %0d expected %0d", nd, T_DONE); end
    checks++; if (pass !== 1'b1)    begin errors++; $display("FAIL ideal_pass: got %b expected 1", pass); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ideal_err: got %0d expected 0", err_cnt); end
    checks++; if (nm != 0)          begin errors++; $display("FAIL ideal_mismatch_pulses: got %0d expected 0", nm); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ideal_busy_done: got %b expected 0", busy); end
    checks++; if (drv !== 1'b0)     begin errors++; $display("FAIL ideal_drv_done: got %b expected 0", drv); end
  endtask

  task automatic test_back_to_back();
    int nd, nm, fm, lm;
    mode  = 0;
    start = 1'b1;
    @(posedge clk1);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_cleared: got %b expected 0", done); end
    watch(0, 0, nd, nm, fm, lm);
    checks++; if (nd != T_DONE)  begin errors++; $display("FAIL b2b_done_edge: got %0d expected %0d", nd, T_DONE); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass: got %b expected 1", pass); end
  endtask

  task automatic test_buffer();
    int nd, nm, fm, lm;
    mode = 1;
    launch();
    watch(0, 0, nd, nm, fm, lm);
    checks++; if (nd != T_DONE)       begin errors++; $display("FAIL buf_done_edge: got %0d expected %0d", nd, T_DONE); end
    checks++; if (err_cnt !== 8'd128) begin errors++; $display("FAIL buf_err: got %0d expected 128", err_cnt); end
    checks++; if (pass !== 1'b0)      begin errors++; $display("FAIL buf_pass: got %b expected 0", pass); end
    checks++; if (nm != 128)          begin errors++; $display("FAIL buf_mismatch_pulses: got %0d expected 128", nm); end
    checks++; if (fm != 3)            begin errors++; $display("FAIL buf_first_mismatch: got %0d expected 3", fm); end
    checks++; if (lm != T_DONE)       begin errors++; $display("FAIL buf_last_mismatch: got %0d expected %0d", lm, T_DONE); end
  endtask

  task automatic test_stuck0();
    int nd, nm, fm, lm;
    mode = 2;
    launch();
    watch(0, 0, nd, nm, fm, lm);
    checks++; if (nd != T_DONE)      begin errors++; $display("FAIL stuck_done_edge: got %0d expected %0d", nd, T_DONE); end
    checks++; if (err_cnt !== 8'd64) begin errors++; $display("FAIL stuck_err: got %0d expected 64", err_cnt); end
    checks++; if (pass !== 1'b0)     begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass); end
  endtask

  task automatic test_glitch();
    int nd, nm, fm, lm;
    mode = 0;
    launch();
    watch(0, 61, nd, nm, fm, lm);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_err: got %0d expected 1", err_cnt); end
    checks++; if (nm != 1)          begin errors++; $display("FAIL glitch_pulses: got %0d expected 1", nm); end
    checks++; if (fm != 61)         begin errors++; $display("FAIL glitch_pulse_edge: got %0d expected 61", fm); end
    checks++; if (pass !== 1'b0)    begin errors++; $display("FAIL glitch_pass: got %b expected 0", pass); end
  endtask

  task automatic test_saturate();
    int nd = -1;
    int nm = 0;
    logic [3:0] err_at20 = 4'd0;
    @(negedge clk1);
    start4 = 1'b1;
    @(posedge clk1);
    #1;
    start4 = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk1);
      #1;
      if (mismatch4) nm++;
      if (n == 20) err_at20 = err_cnt4;
      if (done4) begin
        nd = n;
        break;
      end
    end
    checks++; if (nd != T_DONE)       begin errors++; $display("FAIL sat_done_edge: got %0d expected %0d", nd, T_DONE); end
    checks++; if (err_at20 !== 4'd15) begin errors++; $display("FAIL sat_err_early: got %0d expected 15", err_at20); end
    checks++; if (err_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_err_final: got %0d expected 15", err_cnt4); end
    checks++; if (nm != 128)          begin errors++; $display("FAIL sat_mismatch_pulses: got %0d expected 128", nm); end
    checks++; if (pass4 !== 1'b0)     begin errors++; $display("FAIL sat_pass: got %b expected 0", pass4); end
  endtask

  task automatic test_reset_mid_run();
    int nd, nm, fm, lm;
    mode = 1;
    launch();
    repeat (49) @(posedge clk1);
    #1;
    checks++; if (err_cnt !== 8'd47) begin errors++; $display("FAIL midrst_err_before: got %0d expected 47", err_cnt); end
    rst_n = 1'b0;
    @(posedge clk1);
    #1;
    checks++; if (drv !== 1'b0)       begin errors++; $display("FAIL midrst_drv: got %b expected 0", drv); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (err_cnt !== 8'd0)   begin errors++; $display("FAIL midrst_err: got %0d expected 0", err_cnt); end
    checks++; if (mismatch !== 1'b0)  begin errors++; $display("FAIL midrst_mismatch: got %b expected 0", mismatch); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", dbg_state); end
    @(negedge clk1);
    rst_n = 1'b1;
    mode  = 0;
    launch();
    watch(40, 0, nd, nm, fm, lm);
    checks++; if (nd != T_DONE)     begin errors++; $display("FAIL midrst_rerun_done_edge: got %0d expected %0d", nd, T_DONE); end
    checks++; if (pass !== 1'b1)    begin errors++; $display("FAIL midrst_rerun_pass: got %b expected 1", pass); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_rerun_err: got %0d expected 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_back_to_back();
    test_buffer();
    test_stuck0();
    test_glitch();
    test_saturate();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
